// File: rtl/paged_frame_buffer.sv
// paged_frame_buffer: two-page pixel store; writes and hardware clears go to the back page,
// and the pages swap on a requested frame boundary.
module paged_frame_buffer #(
    parameter int X_BITS = 8,
    parameter int Y_BITS = 7,
    parameter int PIX_W  = 1
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic                     WR_VALID,
    output logic                     WR_READY,
    input  logic [X_BITS+Y_BITS-1:0] WR_ADDR,
    input  logic [PIX_W-1:0]         WR_DATA,
    input  logic [X_BITS+Y_BITS-1:0] RD_ADDR,
    output logic [PIX_W-1:0]         RD_DATA,
    input  logic                     CLEAR_REQ,
    input  logic [PIX_W-1:0]         CLEAR_VALUE,
    input  logic                     FLIP_REQ,
    input  logic                     FRAME_END,
    output logic                     BUSY,
    output logic                     FLIP_PENDING,
    output logic                     FRONT_PAGE
);
    localparam int AW = X_BITS + Y_BITS;
    localparam logic [AW-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, CLEAR, FLIP_WAIT} state_t;

    state_t           state;
    logic [AW-1:0]    clr_cnt;
    logic [PIX_W-1:0] clr_val;
    logic [PIX_W-1:0] mem [0:(2**(AW+1))-1];
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [PIX_W-1:0] mem_din;

    // The fill engine owns the back page while clearing; host writes only land in IDLE.
    assign mem_we   = (state == CLEAR) || (WR_VALID && WR_READY);
    assign mem_addr = (state == CLEAR) ? clr_cnt : WR_ADDR;
    assign mem_din  = (state == CLEAR) ? clr_val : WR_DATA;

    always_ff @(posedge CLK) begin
        if (mem_we)
            mem[{~FRONT_PAGE, mem_addr}] <= mem_din;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)
            RD_DATA <= '0;
        else
            RD_DATA <= mem[{FRONT_PAGE, RD_ADDR}];
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state        <= IDLE;
            WR_READY     <= 1'b1;
            BUSY         <= 1'b0;
            FLIP_PENDING <= 1'b0;
            FRONT_PAGE   <= 1'b0;
            clr_cnt      <= '0;
            clr_val      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CLEAR_REQ) begin
                        state        <= CLEAR;
                        WR_READY     <= 1'b0;
                        BUSY         <= 1'b1;
                        clr_cnt      <= '0;
                        clr_val      <= CLEAR_VALUE;
                        FLIP_PENDING <= FLIP_REQ;
                    end else if (FLIP_REQ) begin
                        state        <= FLIP_WAIT;
                        WR_READY     <= 1'b0;
                        FLIP_PENDING <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (FLIP_REQ)
                        FLIP_PENDING <= 1'b1;
                    // Counter parks on the last address rather than wrapping.
                    if (clr_cnt == LAST) begin
                        state    <= (FLIP_PENDING || FLIP_REQ) ? FLIP_WAIT : IDLE;
                        WR_READY <= !(FLIP_PENDING || FLIP_REQ);
                        BUSY     <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                FLIP_WAIT: begin
                    if (FRAME_END) begin
                        state        <= IDLE;
                        WR_READY     <= 1'b1;
                        FLIP_PENDING <= 1'b0;
                        FRONT_PAGE   <= ~FRONT_PAGE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_paged_frame_buffer.sv
// tb_paged_frame_buffer: directed stimulus against a page-level behavioural model,
// with per-cycle output comparison and hand-computed literal expectations.
module tb_paged_frame_buffer;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 0, rst_n = 0;
    logic          wr_valid = 0, clear_req = 0, flip_req = 0, frame_end = 0;
    logic          wr_ready, busy, flip_pending, front_page;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [3:0]    wr_data = '0, clear_value = '0, rd_data;
    int            n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    paged_frame_buffer #(.X_BITS(3), .Y_BITS(2), .PIX_W(4)) dut (
        .CLK(clk), .RESETN(rst_n), .WR_VALID(wr_valid), .WR_READY(wr_ready),
        .WR_ADDR(wr_addr), .WR_DATA(wr_data), .RD_ADDR(rd_addr), .RD_DATA(rd_data),
        .CLEAR_REQ(clear_req), .CLEAR_VALUE(clear_value), .FLIP_REQ(flip_req),
        .FRAME_END(frame_end), .BUSY(busy), .FLIP_PENDING(flip_pending), .FRONT_PAGE(front_page)
    );

    // Model: two page arrays, words left to clear, and a pending-flip flag.
    logic [3:0] m_mem [2][N];
    bit         m_known [2][N];
    bit         m_front = 0, m_pend = 0, m_rd_known = 1, m_live = 0;
    int         m_left = 0;
    logic [3:0] m_rd = '0, m_clr = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_front = 0; m_pend = 0; m_left = 0; m_rd = '0; m_rd_known = 1;
        end else begin : step
            bit idle;
            idle       = (m_left == 0) && !m_pend;
            m_rd       = m_mem[m_front][rd_addr];
            m_rd_known = m_known[m_front][rd_addr];
            if (idle && wr_valid) begin
                m_mem[!m_front][wr_addr]   = wr_data;
                m_known[!m_front][wr_addr] = 1;
            end
            if (m_left > 0) begin
                m_mem[!m_front][N-m_left]   = m_clr;
                m_known[!m_front][N-m_left] = 1;
                m_left--;
                if (flip_req) m_pend = 1;
            end else if (m_pend) begin
                if (frame_end) begin m_front = !m_front; m_pend = 0; end
            end else if (clear_req) begin
                m_clr = clear_value; m_left = N; m_pend = flip_req;
            end else if (flip_req) begin
                m_pend = 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n && m_live) begin
            chk("cyc_wr_ready", wr_ready, (m_left == 0) && !m_pend);
            chk("cyc_busy", busy, m_left > 0);
            chk("cyc_flip_pending", flip_pending, m_pend);
            chk("cyc_front_page", front_page, m_front);
            if (m_rd_known) chk("cyc_rd_data", rd_data, m_rd);
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wr(input int a, input int d);
        wr_valid = 1; wr_addr = AW'(a); wr_data = 4'(d);
        cyc(1);
        wr_valid = 0;
    endtask

    task automatic flip();
        flip_req = 1; cyc(1); flip_req = 0; cyc(1);
        frame_end = 1; cyc(1); frame_end = 0;
    endtask

    task automatic rd(input int a, input int exp, input string nm);
        rd_addr = AW'(a);
        cyc(1);
        chk(nm, rd_data, exp);
    endtask

    task automatic count_busy(output int n, output bit rdy, input bit pulse_fe);
        n = 0; rdy = 0;
        while (busy === 1'b1 && n < 100) begin
            rdy |= wr_ready;
            frame_end = pulse_fe && (n % 4 == 1);
            n++;
            cyc(1);
        end
        frame_end = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  rdy;
        cyc(2);
        chk("rst_busy", busy, 0);
        chk("rst_front", front_page, 0);
        chk("rst_pending", flip_pending, 0);
        chk("rst_rd_data", rd_data, 0);
        #1 rst_n = 1;
        m_live = 1;
        cyc(1);
        chk("rst_wr_ready", wr_ready, 1);

        for (int a = 0; a < N; a++) wr(a, a == 5 ? 'hA : (a * 5 + 1) & 15);
        flip();
        chk("req023_front", front_page, 1);
        rd(5, 'hA, "req023_rd5");
        rd(3, 'h0, "req023_rd3");

        for (int a = 0; a < N; a++) wr(a, (a + 9) & 15);
        flip();
        chk("page0_front", front_page, 0);

        wr(2, 7);
        rd_addr = 2;
        for (int i = 0; i < 3; i++) begin cyc(1); chk("req028_front_intact", rd_data, 'hB); end
        flip();
        rd(2, 7, "req028_after_swap");

        clear_value = 3; clear_req = 1; cyc(1); clear_req = 0;
        wr_valid = 1; wr_addr = 7; wr_data = 'hF;
        count_busy(n, rdy, 0);
        wr_valid = 0;
        chk("req024_busy_cycles", n, 32);
        chk("req024_ready_seen", rdy, 0);
        flip();
        chk("req024_front", front_page, 0);
        for (int a = 0; a < N; a++) rd(a, 3, "req024_fill");

        clear_value = 5; clear_req = 1; flip_req = 1; cyc(1); clear_req = 0; flip_req = 0;
        count_busy(n, rdy, 1);
        chk("req025_busy_cycles", n, 32);
        chk("req025_no_early_swap", front_page, 0);
        chk("req025_pending", flip_pending, 1);
        frame_end = 1; cyc(1); frame_end = 0;
        chk("req025_swap", front_page, 1);
        chk("req025_pending_clr", flip_pending, 0);

        flip_req = 1; frame_end = 1; cyc(1); flip_req = 0; frame_end = 0;
        chk("req026_no_swap", front_page, 1);
        chk("req026_pending", flip_pending, 1);
        wr_valid = 1; wr_addr = 0; wr_data = 'hF; clear_req = 1;
        cyc(1); clear_req = 0; cyc(2); wr_valid = 0;
        chk("req026_still_pending", flip_pending, 1);
        chk("req017_clear_ignored", busy, 0);
        frame_end = 1; cyc(1); frame_end = 0;
        chk("req026_swap", front_page, 0);
        chk("req026_pending_clr", flip_pending, 0);

        rd_addr = 4;
        clear_value = 'hC; clear_req = 1; cyc(1); clear_req = 0;
        cyc(10);
        #2 rst_n = 0;
        #1;
        chk("req027_busy", busy, 0);
        chk("req027_front", front_page, 0);
        chk("req027_rd_data", rd_data, 0);
        chk("req027_pending", flip_pending, 0);
        @(negedge clk);
        #1 rst_n = 1;
        cyc(1);
        chk("req022_wr_ready", wr_ready, 1);
        flip();
        for (int a = 0; a < N; a++) rd(a, a < 10 ? 'hC : 5, "req027_partial");

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
